// File: rtl/arena_link_pkg.sv
// Shared definitions for the arena/bomb/player snapshot link.
// Frame layout: byte 0 sync, bytes 1..42 body, byte 43 XOR checksum of the body.
// Both ends of the link (transmitter and receiver) import this package.
package arena_link_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int FRAME_BYTES = 44;
    localparam int MAP_BYTES   = 13;
    localparam int MAP_BITS    = 100;

    localparam int ARENA_OFS = 1;
    localparam int BOMB0_OFS = 14;
    localparam int BOMB1_OFS = 27;
    localparam int POS_OFS   = 40;
    localparam int STAT_OFS  = 42;
    localparam int CSUM_OFS  = 43;

    // Body = everything between sync and checksum.
    localparam int BODY_BYTES  = CSUM_OFS - ARENA_OFS;
    localparam int SHADOW_BITS = BODY_BYTES * 8;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        BODY  = 2'd1,
        CHECK = 2'd2
    } frameState_e;

endpackage

// File: rtl/arena_frame_rx_if.sv
// Bundle of the serial input and the registered snapshot outputs.
//   slave  : the receiver (consumes rx, drives the snapshot)
//   master : whoever drives rx and consumes the snapshot
interface arena_frame_rx_if;
    import arena_link_pkg::*;

    logic                rx;
    logic [MAP_BITS-1:0] arena_0;
    logic [MAP_BITS-1:0] bombs_0;
    logic [MAP_BITS-1:0] bombs_1;
    logic [3:0]          playerAx;
    logic [3:0]          playerAy;
    logic [3:0]          playerBx;
    logic [3:0]          playerBy;
    logic [1:0]          playerAhealth;
    logic [1:0]          playerBhealth;
    logic [1:0]          game_state;
    logic                frame_valid;
    logic                frame_err;
    logic                busy;

    modport master (
        output rx,
        input  arena_0, bombs_0, bombs_1,
        input  playerAx, playerAy, playerBx, playerBy,
        input  playerAhealth, playerBhealth, game_state,
        input  frame_valid, frame_err, busy
    );

    modport slave (
        input  rx,
        output arena_0, bombs_0, bombs_1,
        output playerAx, playerAy, playerBx, playerBy,
        output playerAhealth, playerBhealth, game_state,
        output frame_valid, frame_err, busy
    );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver.
//   clk, rst     : clock, async active-low reset
//   rx           : raw serial line (idle high), synchronized internally
//   data         : last received byte, valid while strobe is high
//   strobe       : one-cycle pulse, one cycle after a good stop-bit sample
//   frameErr     : one-cycle pulse, one cycle after a stop-bit sample of 0
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       strobe,
    output logic       frameErr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;  // after a framing error: wait for line high

    logic             rxMeta, rxSync, rxPrev;
    logic [2:0]       st;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bitIdx;
    logic [7:0]       shiftReg;

    assign data = shiftReg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxMeta   <= 1'b1;
            rxSync   <= 1'b1;
            rxPrev   <= 1'b1;
            st       <= S_IDLE;
            cnt      <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            strobe   <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            rxMeta   <= rx;
            rxSync   <= rxMeta;
            rxPrev   <= rxSync;
            strobe   <= 1'b0;
            frameErr <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (rxPrev && !rxSync) begin
                        st  <= S_START;
                        cnt <= '0;
                    end
                end
                S_START: begin
                    // Mid-start re-check rejects glitches without any error.
                    if (cnt == HALF_M1) begin
                        if (rxSync) begin
                            st <= S_IDLE;
                        end else begin
                            st     <= S_DATA;
                            cnt    <= '0;
                            bitIdx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt      <= '0;
                        shiftReg <= {rxSync, shiftReg[7:1]};  // LSB first
                        if (bitIdx == 3'd7) st <= S_STOP;
                        else                bitIdx <= bitIdx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (rxSync) begin
                            strobe <= 1'b1;
                            st     <= S_IDLE;
                        end else begin
                            frameErr <= 1'b1;
                            st       <= S_WAIT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (rxSync) st <= S_IDLE;
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/arena_frame_rx.sv
// Game-state link receiver: recovers bytes, hunts for sync, assembles the
// 44-byte frame into a shadow register and commits it atomically to the
// outputs when the XOR checksum matches.
//   clk, rst : clock, async active-low reset
//   link     : rx in; arena/bomb maps, positions, health, game state,
//              frame_valid / frame_err pulses and busy out
module arena_frame_rx
    import arena_link_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 868,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic             clk,
    input  logic             rst,
    arena_frame_rx_if.slave  link
);

    localparam int GAP_LIMIT = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;
    localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_LIMIT);
    localparam logic [5:0]       LAST_IDX = 6'(BODY_BYTES - 1);

    // Shadow bit positions of each field (shadow byte 0 = frame byte 1).
    localparam int ARENA_LSB = (ARENA_OFS - ARENA_OFS) * 8;
    localparam int BOMB0_LSB = (BOMB0_OFS - ARENA_OFS) * 8;
    localparam int BOMB1_LSB = (BOMB1_OFS - ARENA_OFS) * 8;
    localparam int POS_LSB   = (POS_OFS   - ARENA_OFS) * 8;
    localparam int STAT_LSB  = (STAT_OFS  - ARENA_OFS) * 8;

    logic [7:0]             byteData;
    logic                   byteStrobe;
    logic                   rxFrameErr;

    frameState_e            state;
    logic [5:0]             idx;
    logic [7:0]             acc;
    logic [GAP_W-1:0]       gapCnt;
    logic [SHADOW_BITS-1:0] shadow;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) uRx (
        .clk      (clk),
        .rst      (rst),
        .rx       (link.rx),
        .data     (byteData),
        .strobe   (byteStrobe),
        .frameErr (rxFrameErr)
    );

    assign link.busy = (state != HUNT);

    // Padding bits of the frame that carry no field.
    logic unusedPad;
    assign unusedPad = ^{shadow[BOMB0_LSB-1 -: 4], shadow[BOMB1_LSB-1 -: 4],
                         shadow[POS_LSB-1 -: 4], shadow[SHADOW_BITS-1 -: 2]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= HUNT;
            idx                <= '0;
            acc                <= '0;
            gapCnt             <= '0;
            shadow             <= '0;
            link.arena_0       <= '0;
            link.bombs_0       <= '0;
            link.bombs_1       <= '0;
            link.playerAx      <= '0;
            link.playerAy      <= '0;
            link.playerBx      <= '0;
            link.playerBy      <= '0;
            link.playerAhealth <= '0;
            link.playerBhealth <= '0;
            link.game_state    <= '0;
            link.frame_valid   <= 1'b0;
            link.frame_err     <= 1'b0;
        end else begin
            link.frame_valid <= 1'b0;
            link.frame_err   <= 1'b0;

            if (byteStrobe || state == HUNT) gapCnt <= '0;
            else                             gapCnt <= gapCnt + 1'b1;

            if (byteStrobe) begin
                case (state)
                    HUNT: begin
                        if (byteData == SYNC_BYTE) begin
                            state <= BODY;
                            idx   <= '0;
                            acc   <= '0;
                        end
                    end
                    BODY: begin
                        // Sync value here is ordinary data.
                        shadow[{idx, 3'b000} +: 8] <= byteData;
                        acc <= acc ^ byteData;
                        if (idx == LAST_IDX) state <= CHECK;
                        else                 idx   <= idx + 1'b1;
                    end
                    CHECK: begin
                        if (byteData == acc) begin
                            link.arena_0       <= shadow[ARENA_LSB +: MAP_BITS];
                            link.bombs_0       <= shadow[BOMB0_LSB +: MAP_BITS];
                            link.bombs_1       <= shadow[BOMB1_LSB +: MAP_BITS];
                            link.playerAx      <= shadow[POS_LSB      +: 4];
                            link.playerAy      <= shadow[POS_LSB + 4  +: 4];
                            link.playerBx      <= shadow[POS_LSB + 8  +: 4];
                            link.playerBy      <= shadow[POS_LSB + 12 +: 4];
                            link.playerAhealth <= shadow[STAT_LSB     +: 2];
                            link.playerBhealth <= shadow[STAT_LSB + 2 +: 2];
                            link.game_state    <= shadow[STAT_LSB + 4 +: 2];
                            link.frame_valid   <= 1'b1;
                        end else begin
                            link.frame_err <= 1'b1;
                        end
                        state <= HUNT;
                    end
                    default: state <= HUNT;
                endcase
            end else if (state != HUNT && (rxFrameErr || gapCnt == GAP_MAX)) begin
                // Broken or stalled frame: abandon it, keep the last good snapshot.
                link.frame_err <= 1'b1;
                state          <= HUNT;
            end
        end
    end

endmodule

// File: doc/arena_frame_rx.md
Name: arena_frame_rx

Overview:
- UART receiver and frame parser for the game-state link, i.e. the receiving end of the serial arena/bomb/player snapshot stream.
- Recovers 8N1 bytes on `rx` and hunts for a sync byte.
- Assembles a fixed 44-byte frame and checks an XOR checksum.
- Atomically updates registered copies of arena, bomb maps, player positions, health and game state, which feed a remote vga640x480/sevenSeg instance on a second board.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200); minimum 8.
- TIMEOUT_BYTES, 4: idle gap, in byte times (10*CLKS_PER_BIT), that aborts a partially received frame.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rx  in  1  serial input, idle high, asynchronous to clk
- arena_0  out  100  received arena map (bit i = cell i)
- bombs_0  out  100  received bomb map bit 0
- bombs_1  out  100  received bomb map bit 1
- playerAx, playerAy, playerBx, playerBy  out  4 each  received positions
- playerAhealth, playerBhealth  out  2 each  received health
- game_state  out  2  received game state
- frame_valid  out  1  one-cycle pulse when outputs update
- frame_err  out  1  one-cycle pulse on checksum, framing or timeout failure
- busy  out  1  high while in a frame (states other than HUNT)

Behaviour:
- Reset (rst low, async): all map/position/health/state outputs = 0; frame_valid = frame_err = busy = 0; FSM = HUNT; byte receiver idle.
- rx passes through a 2-flop synchronizer (reset value 1) before any use.
- Byte receiver:
  - Start is detected on a falling edge of synced rx.
  - The start bit is re-checked at CLKS_PER_BIT/2; if high, it is a false start and the receiver returns to idle with no error.
  - Data bits are sampled at the centre of each bit, LSB first.
  - The stop bit is sampled at its centre. If the stop bit is 0: discard the byte, raise an internal framing error, then wait for rx high before re-arming.
  - The byte strobe is asserted one cycle after the stop-bit sample.
- Frame format: byte 0 = SYNC 0xA5.
  - Bytes 1-13: arena_0, LSB-first. Byte k carries bits 8(k-1)..8(k-1)+7; bits 100-103 of byte 13 are ignored.
  - Bytes 14-26: bombs_0, same packing.
  - Bytes 27-39: bombs_1, same packing.
  - Byte 40 = {playerAy, playerAx}; byte 41 = {playerBy, playerBx}.
  - Byte 42 = {2'b0, game_state, playerBhealth, playerAhealth}.
  - Byte 43 = XOR of bytes 1-42.
- FSM:
  - HUNT: any byte != 0xA5 is dropped. On 0xA5, clear the checksum accumulator and byte index, go to BODY.
  - BODY: each byte is written into a 336-bit shadow register at the index and XORed into the accumulator. After index 42, go to CHECK.
  - CHECK: on byte 43, if it equals the accumulator, copy shadow to all outputs in one cycle and pulse frame_valid together with the update. Otherwise pulse frame_err and leave outputs unchanged. Either way, return to HUNT.
- Timeout: a gap counter clears on every byte strobe. In BODY/CHECK, if it reaches TIMEOUT_BYTES*10*CLKS_PER_BIT, pulse frame_err, go to HUNT, keep outputs.
- A framing error in BODY/CHECK pulses frame_err and returns to HUNT. In HUNT it is silent.
- 0xA5 appearing inside BODY is data, not a resync.
- Outputs never show partial frames; the shadow register is never visible.
- Latency: outputs and frame_valid change 2 cycles after the checksum byte's stop-bit sample (1 cycle strobe, 1 cycle commit).
- An async reset mid-frame drops the frame and clears the outputs.

Decomposition:
- Shared package arena_link_pkg:
  - SYNC_BYTE = 8'hA5, FRAME_BYTES = 44, MAP_BYTES = 13.
  - Offsets ARENA_OFS = 1, BOMB0_OFS = 14, BOMB1_OFS = 27, POS_OFS = 40, STAT_OFS = 42, CSUM_OFS = 43.
  - FSM state enum {HUNT, BODY, CHECK}.
  - The matching transmitter uses the same package.
- One sub-module: uart_rx_byte (synchronizer, bit timing, byte strobe, framing error), parameterized by CLKS_PER_BIT.

Test Plan:
- Bench uses CLKS_PER_BIT = 16.
- Valid frame: arena_0 bit 11 and bit 88 set, bombs_0 = 100'h1 << 45, A = (1,1), B = (8,8), health 3/3, state 0 → exactly one frame_valid. Outputs match: playerAx = 1, playerBy = 8, arena_0[11] = 1. frame_err never asserts.
- Corrupt checksum: same frame with byte 43 XOR 0x01 → frame_err pulse, outputs keep the previous frame's values, no frame_valid.
- Garbage then sync: bytes 0x00, 0xFF, 0x5A, then a valid frame → garbage is ignored silently; one frame_valid.
- Timeout: send 0xA5 plus 10 body bytes, then idle 4*160+5 cycles → frame_err. A following full valid frame → frame_valid.
- Framing error: byte 20 sent with stop bit 0 → frame_err and return to HUNT. A subsequent valid frame is accepted.
- Reset mid-frame: assert rst low at byte 30 → all outputs 0 immediately, busy = 0; the remainder of the interrupted frame produces no frame_valid.
